// File: rtl/parking_controller_mp.sv
// parking_controller_mp: one-entrance / one-exit parking gate controller
// with keypad password, entry timeout, retry lockout and full/empty flags.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   sensor_entrance     car waiting at the entrance gate
//   sensor_exit         car waiting at the exit gate
//   password[PW_W]      keypad code, sampled only while password_valid=1
//   password_valid      one-cycle submit strobe
//   GREEN_LED           a gate is open (ENTRY_GRANTED / EXIT_GRANTED)
//   RED_LED             DENIED, FULL or LOCKOUT
//   countcar[CNT_W]     current occupancy
//   indicator[3]        state code
//   full, empty         occupancy at CAPACITY / at zero
//   lockout             keypad locked after MAX_TRIES wrong codes
//   total_entries[16]   saturating count of granted entries
//   total_denials[16]   saturating count of DENIED/LOCKOUT entries
//
// Optional feature: define PARK_STATS_EN to build the statistics
// counters; without it both statistics ports are tied to zero.

module parking_controller_mp #(
    parameter int              CAPACITY    = 15,
    parameter int              CNT_W       = 4,
    parameter int              PW_W        = 4,
    parameter logic [PW_W-1:0] PASSWORD    = 4'b1001,
    parameter int              MAX_TRIES   = 3,
    parameter int              TIMEOUT_CYC = 16,
    parameter int              LOCKOUT_CYC = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic [PW_W-1:0]  password,
    input  logic             password_valid,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [CNT_W-1:0] countcar,
    output logic [2:0]       indicator,
    output logic             full,
    output logic             empty,
    output logic             lockout,
    output logic [15:0]      total_entries,
    output logic [15:0]      total_denials
);

    localparam int TMAX  = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC
                                                       : LOCKOUT_CYC;
    localparam int TMR_W = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] LO_LAST = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE           = 3'b000,
        ENTRY_GRANTED  = 3'b001,
        PASSWORD_CHECK = 3'b010,
        DENIED         = 3'b011,
        EXIT_GRANTED   = 3'b100,
        FULL           = 3'b110,
        LOCKOUT        = 3'b111
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count_n;
    logic [TRY_W-1:0] tries, tries_n;
    logic [TMR_W-1:0] timer, timer_n;

    // Next-state logic. Occupancy guards live in IDLE/FULL only, so the
    // counter can never wrap in either direction.
    always_comb begin
        state_n = state;
        count_n = countcar;
        tries_n = tries;
        timer_n = timer;
        unique case (state)
            IDLE: begin
                if (sensor_exit && !empty) begin
                    state_n = EXIT_GRANTED;
                    count_n = countcar - 1'b1;
                end else if (sensor_entrance && full) begin
                    state_n = FULL;
                end else if (sensor_entrance) begin
                    state_n = PASSWORD_CHECK;
                    timer_n = '0;
                end
            end
            PASSWORD_CHECK: begin
                // A strobe on the last cycle beats the timeout.
                if (password_valid) begin
                    if (password == PASSWORD) begin
                        state_n = ENTRY_GRANTED;
                        count_n = countcar + 1'b1;
                        tries_n = '0;
                    end else if (tries == TRY_LAST) begin
                        state_n = LOCKOUT;
                        tries_n = tries + 1'b1;
                        timer_n = '0;
                    end else begin
                        state_n = DENIED;
                        tries_n = tries + 1'b1;
                    end
                end else if (timer == TO_LAST) begin
                    state_n = DENIED;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ENTRY_GRANTED: begin
                if (!sensor_entrance) state_n = IDLE;
            end
            EXIT_GRANTED: begin
                if (!sensor_exit) state_n = IDLE;
            end
            DENIED: begin
                if (!sensor_entrance) state_n = IDLE;
            end
            FULL: begin
                if (sensor_exit) begin
                    state_n = EXIT_GRANTED;
                    count_n = countcar - 1'b1;
                end else if (!sensor_entrance) begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer == LO_LAST) begin
                    state_n = IDLE;
                    tries_n = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State plus registered Moore outputs decoded from the next values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            countcar  <= '0;
            tries     <= '0;
            timer     <= '0;
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            lockout   <= 1'b0;
        end else begin
            state     <= state_n;
            countcar  <= count_n;
            tries     <= tries_n;
            timer     <= timer_n;
            GREEN_LED <= (state_n == ENTRY_GRANTED) ||
                         (state_n == EXIT_GRANTED);
            RED_LED   <= (state_n == DENIED) || (state_n == FULL) ||
                         (state_n == LOCKOUT);
            full      <= (count_n == CAP);
            empty     <= (count_n == '0);
            lockout   <= (state_n == LOCKOUT);
        end
    end

    assign indicator = state;

`ifdef PARK_STATS_EN
    logic enter_grant, enter_deny;

    assign enter_grant = (state != ENTRY_GRANTED) &&
                         (state_n == ENTRY_GRANTED);
    assign enter_deny  = ((state != DENIED) && (state_n == DENIED)) ||
                         ((state != LOCKOUT) && (state_n == LOCKOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            total_entries <= '0;
            total_denials <= '0;
        end else begin
            if (enter_grant && (total_entries != 16'hFFFF))
                total_entries <= total_entries + 16'd1;
            if (enter_deny && (total_denials != 16'hFFFF))
                total_denials <= total_denials + 16'd1;
        end
    end
`else
    assign total_entries = '0;
    assign total_denials = '0;
`endif

endmodule

// File: tb/tb_parking_controller_mp.sv
// Testbench for parking_controller_mp: table of directed vectors for the
// first scenarios, then hand-written multi-cycle sequences.

module tb_parking_controller_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sensor_entrance = 1'b0;
    logic        sensor_exit = 1'b0;
    logic [3:0]  password = 4'h0;
    logic        password_valid = 1'b0;
    logic        GREEN_LED, RED_LED, full, empty, lockout;
    logic [3:0]  countcar;
    logic [2:0]  indicator;
    logic [15:0] total_entries, total_denials;

    int tests = 0;
    int fails = 0;
    int sb_entries = 0;
    int sb_denials = 0;
    logic [2:0] prev_ind = 3'b000;
    int cnt = 0;

    localparam logic [3:0] GOOD = 4'b1001;
    localparam logic [3:0] BAD  = 4'b1010;

    parking_controller_mp dut (
        .clk             (clk),
        .reset           (reset),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .password        (password),
        .password_valid  (password_valid),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .countcar        (countcar),
        .indicator       (indicator),
        .full            (full),
        .empty           (empty),
        .lockout         (lockout),
        .total_entries   (total_entries),
        .total_denials   (total_denials)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ent, ex, pv;
        logic [3:0] pw;
        logic [2:0] ind;
        logic       g, r;
        logic [3:0] cnt;
        logic       f, e, l;
    } vec_t;

    vec_t tbl [15];

    task automatic step(input logic rs, input logic e, input logic x,
                        input logic v, input logic [3:0] p);
        reset = rs;
        sensor_entrance = e;
        sensor_exit = x;
        password_valid = v;
        password = p;
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs; also advance the statistics scoreboard from
    // the expected state sequence.
    task automatic check(input string nm, input logic rs,
                         input logic [2:0] ind, input logic g,
                         input logic r, input logic [3:0] c,
                         input logic f, input logic e, input logic l);
        logic [11:0] got, want;
        got  = {indicator, GREEN_LED, RED_LED, countcar, full, empty,
                lockout};
        want = {ind, g, r, c, f, e, l};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got ind=%b g=%b r=%b cnt=%0d f=%b e=%b l=%b, want ind=%b g=%b r=%b cnt=%0d f=%b e=%b l=%b",
                     nm, indicator, GREEN_LED, RED_LED, countcar, full,
                     empty, lockout, ind, g, r, c, f, e, l);
        end
        if (rs) begin
            sb_entries = 0;
            sb_denials = 0;
        end else if (ind != prev_ind) begin
            if (ind == 3'b001) sb_entries++;
            if (ind == 3'b011 || ind == 3'b111) sb_denials++;
        end
        prev_ind = ind;
    endtask

    // Expected LEDs and flags follow from state code and occupancy.
    task automatic expect_st(input string nm, input logic [2:0] ind,
                             input int c);
        check(nm, 1'b0, ind,
              (ind == 3'b001) || (ind == 3'b100),
              (ind == 3'b011) || (ind == 3'b110) || (ind == 3'b111),
              4'(c), (c == 15), (c == 0), (ind == 3'b111));
    endtask

    task automatic check_stats(input string nm);
        logic [15:0] we, wd;
`ifdef PARK_STATS_EN
        we = 16'(sb_entries);
        wd = 16'(sb_denials);
`else
        we = 16'd0;
        wd = 16'd0;
`endif
        tests++;
        if (total_entries !== we) begin
            fails++;
            $display("FAIL %s entries: got %0d want %0d", nm,
                     total_entries, we);
        end
        tests++;
        if (total_denials !== wd) begin
            fails++;
            $display("FAIL %s denials: got %0d want %0d", nm,
                     total_denials, wd);
        end
    endtask

    task automatic enter_car();
        step(0, 1, 0, 0, 4'h0);
        expect_st("enter_pc", 3'b010, cnt);
        step(0, 1, 0, 1, GOOD);
        cnt++;
        expect_st("enter_grant", 3'b001, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("enter_idle", 3'b000, cnt);
    endtask

    task automatic leave_car();
        step(0, 0, 1, 0, 4'h0);
        cnt--;
        expect_st("exit_grant", 3'b100, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("exit_idle", 3'b000, cnt);
    endtask

    initial begin
        //          rst ent ex pv pw    ind     g  r  cnt f  e  l
        tbl[0]  = '{1, 0, 0, 0, 4'h0, 3'b000, 0, 0, 4'd0, 0, 1, 0};
        tbl[1]  = '{1, 0, 0, 0, 4'h0, 3'b000, 0, 0, 4'd0, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 4'd0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 4'h0, 3'b010, 0, 0, 4'd0, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, GOOD, 3'b001, 1, 0, 4'd1, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 4'h0, 3'b001, 1, 0, 4'd1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 4'd1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 4'h0, 3'b010, 0, 0, 4'd1, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, BAD,  3'b011, 0, 1, 4'd1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 4'd1, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 4'h0, 3'b010, 0, 0, 4'd1, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 1, BAD,  3'b011, 0, 1, 4'd1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 4'd1, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 4'h0, 3'b010, 0, 0, 4'd1, 0, 0, 0};
        tbl[14] = '{0, 1, 0, 1, BAD,  3'b111, 0, 1, 4'd1, 0, 0, 1};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].ent, tbl[i].ex, tbl[i].pv, tbl[i].pw);
            check($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ind,
                  tbl[i].g, tbl[i].r, tbl[i].cnt, tbl[i].f, tbl[i].e,
                  tbl[i].l);
        end
        cnt = 1;
        check_stats("after_table");

        // Lockout: 31 more edges locked with both sensors ignored.
        for (int i = 0; i < 31; i++) begin
            step(0, 1, 1, 0, 4'h0);
            expect_st($sformatf("lock_hold%0d", i), 3'b111, cnt);
        end
        step(0, 0, 0, 0, 4'h0);
        expect_st("lock_expire", 3'b000, cnt);

        // Tries cleared: one wrong code only denies.
        step(0, 1, 0, 0, 4'h0);
        expect_st("retry_pc", 3'b010, cnt);
        step(0, 1, 0, 1, BAD);
        expect_st("retry_denied", 3'b011, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("retry_idle", 3'b000, cnt);

        // Timeout: DENIED on the 16th edge after entering the check.
        step(0, 1, 0, 0, 4'h0);
        expect_st("to_pc", 3'b010, cnt);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 0, 0, 4'h0);
            expect_st($sformatf("to_wait%0d", i), 3'b010, cnt);
        end
        step(0, 1, 0, 0, 4'h0);
        expect_st("to_denied", 3'b011, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("to_idle", 3'b000, cnt);

        // Timeout added no try: second wrong code is DENIED, not LOCKOUT.
        step(0, 1, 0, 0, 4'h0);
        expect_st("to_retry_pc", 3'b010, cnt);
        step(0, 1, 0, 1, BAD);
        expect_st("to_retry_denied", 3'b011, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("to_retry_idle", 3'b000, cnt);
        check_stats("after_timeout");

        // Fill the lot.
        while (cnt < 15) enter_car();
        step(0, 1, 0, 0, 4'h0);
        expect_st("full_state", 3'b110, cnt);
        step(0, 1, 1, 0, 4'h0);
        cnt--;
        expect_st("full_exit", 3'b100, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("full_exit_idle", 3'b000, cnt);

        // Down to 5, then both sensors: exit wins.
        while (cnt > 5) leave_car();
        step(0, 1, 1, 0, 4'h0);
        cnt--;
        expect_st("both_exit", 3'b100, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("both_idle", 3'b000, cnt);

        // Empty lot: exit is ignored.
        while (cnt > 0) leave_car();
        step(0, 0, 1, 0, 4'h0);
        expect_st("empty_exit", 3'b000, cnt);
        step(0, 0, 0, 0, 4'h0);
        expect_st("empty_idle", 3'b000, cnt);
        check_stats("after_scenarios");

        // Reset mid-operation clears occupancy and statistics.
        enter_car();
        step(0, 1, 0, 0, 4'h0);
        expect_st("pre_reset_pc", 3'b010, cnt);
        step(1, 1, 0, 0, 4'h0);
        cnt = 0;
        check("mid_reset", 1'b1, 3'b000, 0, 0, 4'd0, 0, 1, 0);
        check_stats("after_reset");
        step(0, 0, 0, 0, 4'h0);
        expect_st("post_reset_idle", 3'b000, cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parking_controller_mp.md
# parking_controller_mp

Parametrised next-generation parking-lot gate controller: one entrance and one exit lane, configurable capacity, counter width and password. Adds several features over the plain controller: a password strobe, a password-entry timeout, a retry counter with timed lockout, defined simultaneous entry/exit arbitration, and explicit full/empty flags. Sits between the gate sensors/keypad and the lane LEDs; `countcar` feeds the occupancy display.

## Interface
- `CAPACITY`, 15, maximum parked cars; must satisfy 1 ≤ CAPACITY ≤ 2^CNT_W−1
- `CNT_W`, 4, width of `countcar`
- `PW_W`, 4, password width
- `PASSWORD`, 4'b1001, accepted code (PW_W bits)
- `MAX_TRIES`, 3, consecutive wrong codes that trigger lockout (≥1)
- `TIMEOUT_CYC`, 16, cycles allowed in PASSWORD_CHECK without a strobe (≥2)
- `LOCKOUT_CYC`, 32, cycles spent in LOCKOUT (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `sensor_entrance` in 1: car present at entrance
- `sensor_exit` in 1: car present at exit
- `password` in PW_W: keypad code, sampled only when `password_valid`=1
- `password_valid` in 1: one-cycle submit strobe
- `GREEN_LED` out 1: gate open (ENTRY_GRANTED or EXIT_GRANTED)
- `RED_LED` out 1: DENIED, FULL or LOCKOUT
- `countcar` out CNT_W: current occupancy
- `indicator` out 3: state code
- `full` out 1: countcar == CAPACITY
- `empty` out 1: countcar == 0
- `lockout` out 1: state is LOCKOUT
- `total_entries` out 16, `total_denials` out 16: statistics (see Configuration)

## Operation
State codes on `indicator`: IDLE 000, ENTRY_GRANTED 001, PASSWORD_CHECK 010, DENIED 011, EXIT_GRANTED 100, FULL 110, LOCKOUT 111.

Transitions:
- **IDLE**
  - `sensor_exit` && !empty → EXIT_GRANTED. Exit has priority over entrance.
  - else `sensor_entrance` && full → FULL.
  - else `sensor_entrance` → PASSWORD_CHECK; the timer clears.
  - `sensor_exit` while empty is ignored.
- **PASSWORD_CHECK**
  - `password_valid` && code == PASSWORD → ENTRY_GRANTED; countcar+1; tries cleared.
  - `password_valid` && mismatch → tries+1; if the new tries == MAX_TRIES → LOCKOUT, else DENIED.
  - no strobe and timer == TIMEOUT_CYC−1 → DENIED. No try is counted.
  - A strobe on the timeout cycle takes precedence over the timeout.
  - `sensor_entrance` is not monitored here.
- **ENTRY_GRANTED** → IDLE when `sensor_entrance`=0. The minimum stay is 1 cycle.
- **EXIT_GRANTED**: countcar−1 on entry to the state. → IDLE when `sensor_exit`=0.
- **DENIED** → IDLE when `sensor_entrance`=0.
- **FULL**
  - `sensor_exit` → EXIT_GRANTED.
  - else `sensor_entrance`=0 → IDLE.
- **LOCKOUT**: timer runs LOCKOUT_CYC cycles, then → IDLE with tries cleared. Both sensors are ignored for the whole lockout.

Arithmetic and boundaries:
- countcar is updated on the same edge as the grant state is entered.
- It never exceeds CAPACITY and never goes below 0. The guards are in IDLE, so no wrap is possible.
- The tries counter persists across DENIED and IDLE. It clears only on a correct code, on lockout expiry, or on reset.

## Timing
- All outputs are Moore, decoded from registers with no combinational input-to-output path.
- Sensor asserted at edge N is sampled at edge N. The new `indicator`, LEDs and `countcar` are visible after edge N.
- Correct strobe at edge N: GREEN_LED=1 and countcar+1 after edge N.
- Timeout: with no strobe, DENIED is entered exactly TIMEOUT_CYC edges after entering PASSWORD_CHECK.
- LOCKOUT lasts exactly LOCKOUT_CYC cycles.
- Reset values: state IDLE, indicator 000, countcar 0, tries 0, timer 0, GREEN_LED 0, RED_LED 0, full 0, empty 1, lockout 0, stats 0.
- Reset asserted mid-operation, in any state, returns all state to these reset values on that edge. Occupancy is lost.

## Configuration
- `PARK_STATS_EN` defined:
  - `total_entries` increments on every ENTRY_GRANTED entry.
  - `total_denials` increments on every DENIED or LOCKOUT entry.
  - FULL rejections are not counted.
  - Both counters are 16-bit, saturate at 16'hFFFF and clear on reset.
- Not defined: both ports remain, tied to 0, and no counter registers are synthesised.

## Test plan
- Reset held 2 cycles then released → countcar=0, empty=1, indicator=000, both LEDs 0.
- Entrance=1, strobe 4'b1001 → indicator 010 then 001; GREEN_LED=1, countcar=1. Entrance dropped → IDLE.
- Three wrong strobes (4'b1010) across three entrance attempts:
  - attempts 1–2 → DENIED with RED_LED=1;
  - attempt 3 → indicator 111, lockout=1 for 32 cycles, then IDLE with tries cleared.
- Entrance held with no strobe for 16 cycles → DENIED on the 16th edge; countcar unchanged; a following correct code still needs 3 bad tries to lock.
- Fill to 15, then entrance → FULL with RED_LED=1 and countcar=15. Exit during FULL → EXIT_GRANTED and countcar=14.
- Both sensors asserted in IDLE with countcar=5 → EXIT_GRANTED, countcar=4. Exit at countcar=0 → stays IDLE.
- With `PARK_STATS_EN`, after the scenarios above, `total_entries` and `total_denials` match the scoreboard.
